// File: rtl/pt_pkg.sv
// pt_pkg: shared state encoding and default constants for the QRS decision logic
package pt_pkg;
    typedef enum logic [1:0] {LEARN, DETECT, REFRACT} state_t;
    localparam int PT_DATA_WIDTH     = 16;
    localparam int PT_COUNT_WIDTH    = 12;
    localparam int PT_LEARN_CYCLES   = 400;
    localparam int PT_REFRACT_CYCLES = 40;
    localparam int PT_RR_MAX         = 400;
endpackage

// File: rtl/pt_level_avg.sv
// pt_level_avg: one-eighth running-average step, clamped to [0, max positive]
module pt_level_avg #(
    parameter int DATA_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0] level,
    input  logic signed [DATA_WIDTH-1:0] sample,
    output logic signed [DATA_WIDTH-1:0] result
);
    localparam int W = DATA_WIDTH + 2;
    localparam logic signed [W-1:0] TOP = W'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    logic signed [W-1:0] sum;
    always_comb begin
        sum = W'(level) - W'(level >>> 3) + W'(sample >>> 3);
        result = sum < 0 ? '0 : sum > TOP ? TOP[DATA_WIDTH-1:0] : sum[DATA_WIDTH-1:0];
    end
endmodule

// File: rtl/qrs_decision_ctrl.sv
// qrs_decision_ctrl: learn/detect/refractory QRS classifier with adaptive threshold
module qrs_decision_ctrl
    import pt_pkg::*;
#(
    parameter int DATA_WIDTH     = PT_DATA_WIDTH,
    parameter int COUNT_WIDTH    = PT_COUNT_WIDTH,
    parameter int LEARN_CYCLES   = PT_LEARN_CYCLES,
    parameter int REFRACT_CYCLES = PT_REFRACT_CYCLES,
    parameter int RR_MAX         = PT_RR_MAX
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          peak_flag,
    input  logic signed [DATA_WIDTH-1:0]  peak_val,
    output logic                          timer_activation,
    output logic                          qrs_valid,
    output logic signed [DATA_WIDTH-1:0]  qrs_amp,
    output logic                          noise_valid,
    output logic                          missed,
    output logic signed [DATA_WIDTH-1:0]  threshold,
    output logic [COUNT_WIDTH-1:0]        rr_count
);
    localparam int W = DATA_WIDTH + 2;
    localparam logic signed [W-1:0] TOP = W'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [W-1:0] BOT = -TOP - W'(1);
    localparam logic [COUNT_WIDTH-1:0] LEARN_LIM = COUNT_WIDTH'(LEARN_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] REF_LIM   = COUNT_WIDTH'(REFRACT_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] RR_LIM    = COUNT_WIDTH'(RR_MAX);

    state_t state;
    logic [COUNT_WIDTH-1:0] phase, phase_next, rr_cnt, rr_next;
    logic signed [DATA_WIDTH-1:0] spki, npki, pk_max, pk_clamp, pk_new, spki_qrs, npki_noise;
    logic signed [W-1:0] thr_wide;
    logic qrs_hit, noise_hit, timeout;

    pt_level_avg #(.DATA_WIDTH(DATA_WIDTH)) u_spki (.level(spki), .sample(peak_val), .result(spki_qrs));
    pt_level_avg #(.DATA_WIDTH(DATA_WIDTH)) u_npki (.level(npki), .sample(peak_val), .result(npki_noise));

    always_comb begin
        phase_next = phase + 1'b1;
        rr_next = &rr_cnt ? rr_cnt : rr_cnt + 1'b1;
        pk_clamp = peak_val[DATA_WIDTH-1] ? '0 : peak_val;
        pk_new = (peak_flag && pk_clamp > pk_max) ? pk_clamp : pk_max;
        thr_wide = W'(npki) + ((W'(spki) - W'(npki)) >>> 2);
        threshold = thr_wide > TOP ? TOP[DATA_WIDTH-1:0] : thr_wide < BOT ? BOT[DATA_WIDTH-1:0] : thr_wide[DATA_WIDTH-1:0];
        qrs_hit = en && state == DETECT && peak_flag && peak_val >= threshold;
        noise_hit = en && state == DETECT && peak_flag && peak_val < threshold;
        // a simultaneous QRS decision suppresses the timeout
        timeout = en && state == DETECT && !qrs_hit && rr_next >= RR_LIM;
        timer_activation = state == REFRACT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LEARN;
            phase       <= '0;
            rr_cnt      <= '0;
            spki        <= '0;
            npki        <= '0;
            pk_max      <= '0;
            qrs_valid   <= 1'b0;
            noise_valid <= 1'b0;
            missed      <= 1'b0;
            qrs_amp     <= '0;
            rr_count    <= '0;
        end else begin
            qrs_valid   <= qrs_hit;
            noise_valid <= noise_hit;
            missed      <= timeout;
            if (en) begin
                case (state)
                    LEARN: begin
                        pk_max <= pk_new;
                        phase  <= phase_next;
                        if (phase_next == LEARN_LIM) begin
                            spki  <= pk_new >>> 2;
                            npki  <= pk_new >>> 3;
                            phase <= '0;
                            state <= DETECT;
                        end
                    end
                    DETECT: begin
                        rr_cnt <= rr_next;
                        if (qrs_hit) begin
                            spki     <= spki_qrs;
                            qrs_amp  <= peak_val;
                            rr_count <= rr_next;
                            rr_cnt   <= '0;
                            phase    <= '0;
                            state    <= REFRACT;
                        end else begin
                            if (noise_hit) npki <= npki_noise;
                            if (timeout) begin
                                spki   <= spki >>> 1;
                                rr_cnt <= '0;
                            end
                        end
                    end
                    REFRACT: begin
                        rr_cnt <= rr_next;
                        phase  <= phase_next;
                        if (phase_next == REF_LIM) begin
                            phase <= '0;
                            state <= DETECT;
                        end
                    end
                    default: state <= LEARN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_qrs_decision_ctrl.sv
// tb_qrs_decision_ctrl: directed checks of learning, classification, refractory, timeout, en and reset
module tb_qrs_decision_ctrl;
    import pt_pkg::*;
    logic clk = 1'b0;
    logic rst, en, peak_flag;
    logic signed [15:0] peak_val;
    logic timer_activation, qrs_valid, noise_valid, missed;
    logic signed [15:0] qrs_amp, threshold;
    logic [11:0] rr_count;
    int n_cmp = 0;
    int n_bad = 0;

    qrs_decision_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .peak_flag(peak_flag), .peak_val(peak_val),
        .timer_activation(timer_activation), .qrs_valid(qrs_valid), .qrs_amp(qrs_amp),
        .noise_valid(noise_valid), .missed(missed), .threshold(threshold), .rr_count(rr_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; peak_flag = 1'b0; peak_val = '0;
        tick(2);
        check("rst_threshold", threshold, 0);
        check("rst_qrs_amp", qrs_amp, 0);
        check("rst_rr_count", 32'(rr_count), 0);
        check("rst_timer", 32'(timer_activation), 0);
        check("rst_pulses", 32'({qrs_valid, noise_valid, missed}), 0);
        check("rst_state", 32'(dut.state), 32'(LEARN));

        rst = 1'b0; en = 1'b1;
        peak_flag = 1'b1; peak_val = 16'sd1000; tick(1);
        peak_val = -16'sd500; tick(1);
        peak_val = 16'sd300; tick(1);
        peak_flag = 1'b0; peak_val = '0; tick(396);
        check("learn_399_state", 32'(dut.state), 32'(LEARN));
        check("learn_399_thr", threshold, 0);
        check("learn_no_pulse", 32'({qrs_valid, noise_valid, missed}), 0);
        tick(1);
        check("learn_state", 32'(dut.state), 32'(DETECT));
        check("learn_spki", dut.spki, 250);
        check("learn_npki", dut.npki, 125);
        check("learn_thr", threshold, 156);

        peak_flag = 1'b1; peak_val = 16'sd100; tick(1);
        check("noise_valid", 32'(noise_valid), 1);
        check("noise_qrs", 32'(qrs_valid), 0);
        check("noise_npki", dut.npki, 122);
        check("noise_timer", 32'(timer_activation), 0);
        check("noise_thr", threshold, 154);
        peak_flag = 1'b0; tick(1);
        check("noise_one_cycle", 32'(noise_valid), 0);

        peak_flag = 1'b1; peak_val = 16'sd800; tick(1);
        check("qrs_valid", 32'(qrs_valid), 1);
        check("qrs_amp", qrs_amp, 800);
        check("qrs_spki", dut.spki, 319);
        check("qrs_rr", 32'(rr_count), 3);
        check("qrs_timer", 32'(timer_activation), 1);
        peak_flag = 1'b0; tick(1);
        check("qrs_one_cycle", 32'(qrs_valid), 0);
        tick(8);
        peak_flag = 1'b1; peak_val = 16'sd2000; tick(1);
        check("refr_ignore_qrs", 32'(qrs_valid), 0);
        check("refr_ignore_noise", 32'(noise_valid), 0);
        check("refr_spki", dut.spki, 319);
        peak_flag = 1'b0;

        en = 1'b0; tick(50);
        check("en0_phase", 32'(dut.phase), 10);
        check("en0_rr", 32'(dut.rr_cnt), 10);
        check("en0_timer", 32'(timer_activation), 1);
        check("en0_pulses", 32'({qrs_valid, noise_valid, missed}), 0);

        en = 1'b1; tick(29);
        check("refr_39_timer", 32'(timer_activation), 1);
        peak_flag = 1'b1; peak_val = 16'sd2000; tick(1);
        check("expiry_timer", 32'(timer_activation), 0);
        check("expiry_flag_ignored", 32'(qrs_valid), 0);
        check("expiry_spki", dut.spki, 319);
        check("expiry_rr", 32'(dut.rr_cnt), 40);
        peak_flag = 1'b0;

        tick(359);
        check("pre_timeout", 32'(missed), 0);
        tick(1);
        check("timeout_missed", 32'(missed), 1);
        check("timeout_spki", dut.spki, 159);
        check("timeout_rr", 32'(dut.rr_cnt), 0);
        check("timeout_thr", threshold, 131);
        tick(1);
        check("missed_one_cycle", 32'(missed), 0);
        tick(398);
        peak_flag = 1'b1; peak_val = 16'sd500; tick(1);
        check("tie_qrs", 32'(qrs_valid), 1);
        check("tie_no_missed", 32'(missed), 0);
        check("tie_rr", 32'(rr_count), 400);
        check("tie_amp", qrs_amp, 500);
        check("tie_spki", dut.spki, 202);
        peak_flag = 1'b0;

        tick(5);
        rst = 1'b1; tick(1);
        check("rstmid_state", 32'(dut.state), 32'(LEARN));
        check("rstmid_timer", 32'(timer_activation), 0);
        check("rstmid_thr", threshold, 0);
        check("rstmid_amp", qrs_amp, 0);
        check("rstmid_rr", 32'(rr_count), 0);
        check("rstmid_pulses", 32'({qrs_valid, noise_valid, missed}), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
